// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, the controller state encoding and
// the bit-reversal helper used to map natural-order bins onto core slots.
package fft_pkg;

  localparam int FFT_N     = 8;
  localparam int FFT_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_UNLOAD
  } fft_state_e;

  // Reverses the low aw bits of value; bits above aw come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int aw);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < aw) r[i] = value[aw-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft8_stream_ctrl.sv
// Frame sequencer around the FFT core: streams N samples into the core, starts it,
// waits for done under a watchdog, then streams N bins out in natural order.
module fft8_stream_ctrl
  import fft_pkg::*;
#(
  parameter int N          = FFT_N,
  parameter int WIDTH      = FFT_WIDTH,
  parameter int OUT_BITREV = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_re,
  input  logic [WIDTH-1:0]         s_im,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_re,
  output logic [WIDTH-1:0]         m_im,
  output logic                     m_last,
  output logic                     core_load,
  output logic [$clog2(N)-1:0]     core_load_addr,
  output logic [WIDTH-1:0]         core_data_re,
  output logic [WIDTH-1:0]         core_data_im,
  output logic                     core_start,
  input  logic                     core_done,
  output logic [$clog2(N)-1:0]     core_out_addr,
  input  logic [WIDTH-1:0]         core_out_re,
  input  logic [WIDTH-1:0]         core_out_im,
  output logic                     err_len,
  output logic                     err_timeout,
  output logic [15:0]              frame_cnt
);

  localparam int AW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT);

  fft_state_e       state_q, state_d;
  logic [AW-1:0]    in_cnt_q, in_cnt_d;
  logic [AW-1:0]    out_cnt_q, out_cnt_d;
  logic [WW-1:0]    wd_cnt_q, wd_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      wd_cnt_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // All strobes and valids are gated by rst so they drop in the reset cycle itself.
  always_comb begin
    state_d        = state_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    wd_cnt_d       = wd_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    s_ready        = 1'b0;
    m_valid        = 1'b0;
    m_last         = 1'b0;
    m_re           = core_out_re;
    m_im           = core_out_im;
    core_load      = 1'b0;
    core_load_addr = in_cnt_q;
    core_data_re   = s_re;
    core_data_im   = s_im;
    core_start     = 1'b0;
    core_out_addr  = '0;
    err_len        = 1'b0;
    err_timeout    = 1'b0;

    if (!rst) begin
      case (state_q)
        ST_LOAD: begin
          s_ready = 1'b1;
          if (s_valid) begin
            core_load = 1'b1;
            if (in_cnt_q == AW'(N-1)) begin
              // A full frame is processed even when s_last is missing.
              state_d  = ST_START;
              in_cnt_d = '0;
              err_len  = !s_last;
            end else if (s_last) begin
              in_cnt_d = '0;
              err_len  = 1'b1;
            end else begin
              in_cnt_d = in_cnt_q + 1'b1;
            end
          end
        end
        ST_START: begin
          core_start = 1'b1;
          wd_cnt_d   = '0;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            state_d   = ST_UNLOAD;
            out_cnt_d = '0;
          end else if (wd_cnt_q == WW'(TIMEOUT-1)) begin
            err_timeout = 1'b1;
            state_d     = ST_LOAD;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
        ST_UNLOAD: begin
          m_valid = 1'b1;
          if (OUT_BITREV != 0) core_out_addr = AW'(bitrev(32'(out_cnt_q), AW));
          else                 core_out_addr = out_cnt_q;
          m_last = (out_cnt_q == AW'(N-1));
          if (m_ready) begin
            out_cnt_d = out_cnt_q + 1'b1;
            if (m_last) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
              state_d     = ST_LOAD;
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  assign frame_cnt = rst ? 16'd0 : frame_cnt_q;

endmodule

// File: tb/tb_fft8_stream_ctrl.sv
// Randomized scoreboard bench for fft8_stream_ctrl with a mock FFT core; a bit-reversed
// and a natural-order instance run in lockstep on the same stimulus.
module tb_fft8_stream_ctrl;

  localparam int N   = 8;
  localparam int W   = 12;
  localparam int AW  = 3;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [W-1:0]  s_re = '0, s_im = '0;
  logic          s_ready, m_valid, m_last, core_load, core_start, core_done;
  logic [W-1:0]  m_re, m_im, core_data_re, core_data_im, core_out_re, core_out_im;
  logic [AW-1:0] core_load_addr, core_out_addr;
  logic          err_len, err_timeout;
  logic [15:0]   frame_cnt;

  logic          s_ready2, m_valid2, m_last2, core_load2, core_start2, err_len2, err_timeout2;
  logic [W-1:0]  m_re2, m_im2, core_data_re2, core_data_im2, core_out_re2, core_out_im2;
  logic [AW-1:0] core_load_addr2, core_out_addr2;
  logic [15:0]   frame_cnt2;

  fft8_stream_ctrl #(.N(N), .WIDTH(W), .OUT_BITREV(1), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im), .m_last(m_last),
    .core_load(core_load), .core_load_addr(core_load_addr),
    .core_data_re(core_data_re), .core_data_im(core_data_im),
    .core_start(core_start), .core_done(core_done), .core_out_addr(core_out_addr),
    .core_out_re(core_out_re), .core_out_im(core_out_im),
    .err_len(err_len), .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  fft8_stream_ctrl #(.N(N), .WIDTH(W), .OUT_BITREV(0), .TIMEOUT(TMO)) dut_nat (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready2), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .m_valid(m_valid2), .m_ready(m_ready), .m_re(m_re2), .m_im(m_im2), .m_last(m_last2),
    .core_load(core_load2), .core_load_addr(core_load_addr2),
    .core_data_re(core_data_re2), .core_data_im(core_data_im2),
    .core_start(core_start2), .core_done(core_done), .core_out_addr(core_out_addr2),
    .core_out_re(core_out_re2), .core_out_im(core_out_im2),
    .err_len(err_len2), .err_timeout(err_timeout2), .frame_cnt(frame_cnt2)
  );

  // Mock core: register file written by the load port, done after lat cycles.
  logic [W-1:0] mem_re [N];
  logic [W-1:0] mem_im [N];
  logic [7:0]   dcnt;
  int unsigned  lat = 3;
  bit           no_done = 1'b0;
  bit           early_done = 1'b0;

  always @(posedge clk) begin
    if (core_load) begin
      mem_re[core_load_addr] <= core_data_re;
      mem_im[core_load_addr] <= core_data_im;
    end
    if (rst)                          dcnt <= 8'd0;
    else if (core_start && !no_done)  dcnt <= 8'(lat);
    else if (dcnt != 8'd0)            dcnt <= dcnt - 8'd1;
  end

  assign core_done    = (dcnt == 8'd1) || (early_done && core_start);
  assign core_out_re  = mem_re[core_out_addr] ^ 12'h5A5;
  assign core_out_im  = mem_im[core_out_addr] + {9'd0, core_out_addr};
  assign core_out_re2 = mem_re[core_out_addr2] ^ 12'h5A5;
  assign core_out_im2 = mem_im[core_out_addr2] + {9'd0, core_out_addr2};

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic int brev(input int v);
    int r, t;
    r = 0;
    t = v;
    for (int b = 0; b < AW; b++) begin
      r = r * 2 + (t % 2);
      t = t / 2;
    end
    return r;
  endfunction

  typedef struct {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [AW-1:0] addr;
    logic          last;
  } beat_t;

  beat_t q1[$];
  beat_t q2[$];
  int    beats_seen = 0;
  int    tmo_seen = 0;

  // Protocol model: expected handshake/strobe timing derived from the frame rules.
  bit exp_sready = 1'b0, exp_mvalid = 1'b0, start_next = 1'b0, waiting = 1'b0;
  int wcnt = 0, idx = 0, ocnt = 0, frames = 0;

  initial begin : protocol_mon
    bit acc, done_hit, tmo, beat, lastbeat, lenerr;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_valid_nat", m_valid2, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_core_load", core_load, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        exp_sready = 1'b1; exp_mvalid = 1'b0; start_next = 1'b0; waiting = 1'b0;
        wcnt = 0; idx = 0; ocnt = 0; frames = 0;
      end else begin
        acc      = s_valid && exp_sready;
        done_hit = waiting && core_done;
        tmo      = waiting && !core_done && (wcnt + 1 == TMO);
        beat     = exp_mvalid && m_ready;
        lastbeat = beat && (ocnt == N-1);
        lenerr   = acc && ((idx == N-1) != s_last);
        chk("s_ready", s_ready, exp_sready);
        chk("m_valid", m_valid, exp_mvalid);
        chk("m_valid_nat", m_valid2, exp_mvalid);
        chk("m_last", m_last, exp_mvalid && (ocnt == N-1));
        chk("core_start", core_start, start_next);
        chk("core_load", core_load, acc);
        chk("err_len", err_len, lenerr);
        chk("err_timeout", err_timeout, tmo);
        chk("frame_cnt", frame_cnt, frames);
        if (acc) begin
          chk("core_load_addr", core_load_addr, idx);
          chk("core_data_re", core_data_re, s_re);
          chk("core_data_im", core_data_im, s_im);
        end
        if (tmo) tmo_seen++;
        if (waiting) begin
          if (done_hit || tmo) waiting = 1'b0;
          else                 wcnt++;
        end
        if (start_next) begin
          waiting = 1'b1;
          wcnt    = 0;
        end
        start_next = acc && (idx == N-1);
        exp_mvalid = (exp_mvalid && !lastbeat) || done_hit;
        exp_sready = (exp_sready && !(acc && idx == N-1)) || tmo || lastbeat;
        if (beat)     ocnt = (ocnt == N-1) ? 0 : ocnt + 1;
        if (lastbeat) frames++;
        if (acc)      idx = (idx == N-1 || s_last) ? 0 : idx + 1;
      end
    end
  end

  // Scoreboard: pops expected bins on every output handshake and checks stall stability.
  initial begin : scoreboard
    beat_t e;
    bit st1 = 1'b0, st2 = 1'b0;
    logic [W-1:0] pr1, pi1, pr2, pi2;
    logic [AW-1:0] pa1, pa2;
    forever begin
      @(negedge clk);
      if (rst) begin
        q1.delete();
        q2.delete();
        st1 = 1'b0;
        st2 = 1'b0;
      end else begin
        if (st1) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_re", m_re, pr1);
          chk("stall_im", m_im, pi1);
          chk("stall_addr", core_out_addr, pa1);
        end
        if (st2) begin
          chk("stall_valid_nat", m_valid2, 1);
          chk("stall_re_nat", m_re2, pr2);
          chk("stall_addr_nat", core_out_addr2, pa2);
        end
        if (m_valid && m_ready) begin
          if (q1.size() == 0) note_fail("unexpected_beat");
          else begin
            e = q1.pop_front();
            chk("bin_re", m_re, e.re);
            chk("bin_im", m_im, e.im);
            chk("out_addr", core_out_addr, e.addr);
            chk("bin_last", m_last, e.last);
          end
          beats_seen++;
        end
        if (m_valid2 && m_ready) begin
          if (q2.size() == 0) note_fail("unexpected_beat_nat");
          else begin
            e = q2.pop_front();
            chk("bin_re_nat", m_re2, e.re);
            chk("bin_im_nat", m_im2, e.im);
            chk("out_addr_nat", core_out_addr2, e.addr);
            chk("bin_last_nat", m_last2, e.last);
          end
        end
        st1 = m_valid && !m_ready;
        st2 = m_valid2 && !m_ready;
        pr1 = m_re;  pi1 = m_im;  pa1 = core_out_addr;
        pr2 = m_re2; pi2 = m_im2; pa2 = core_out_addr2;
      end
    end
  end

  int       rmode = 0;
  bit [3:0] pat = 4'b1001;
  int       ph = 0;

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       m_ready = 1'b1;
        1: begin m_ready = pat[ph]; ph = (ph + 1) % 4; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_frame(input int len, input bit mark_last, input bit ramp, input bit expect_out);
    logic [W-1:0] xr [N];
    logic [W-1:0] xi [N];
    beat_t b;
    int guard, slot;
    for (int i = 0; i < len; i++) begin
      xr[i] = ramp ? W'(i) : W'($urandom);
      xi[i] = ramp ? '0 : W'($urandom);
      if (!ramp && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_re    = xr[i];
      s_im    = xi[i];
      s_last  = (i == len - 1) && mark_last;
      guard   = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!s_ready && guard < 400);
      if (!s_ready) note_fail("s_ready_wait");
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    if (expect_out && len == N) begin
      for (int k = 0; k < N; k++) begin
        slot   = brev(k);
        b.re   = xr[slot] ^ 12'h5A5;
        b.im   = xi[slot] + W'(slot);
        b.addr = AW'(slot);
        b.last = (k == N-1);
        q1.push_back(b);
        b.re   = xr[k] ^ 12'h5A5;
        b.im   = xi[k] + W'(k);
        b.addr = AW'(k);
        q2.push_back(b);
      end
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((q1.size() != 0 || q2.size() != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (q1.size() != 0 || q2.size() != 0) note_fail("drain_wait");
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base, guard;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    // Nominal ramp frame.
    rmode = 0; lat = 5;
    send_frame(N, 1'b1, 1'b1, 1'b1);
    wait_idle();
    chk("frame_cnt_nominal", frame_cnt, 1);

    // Output backpressure 1,0,0,1.
    rmode = 1; lat = 3;
    send_frame(N, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Short frame dropped, then a normal frame.
    rmode = 2;
    send_frame(5, 1'b1, 1'b0, 1'b0);
    send_frame(N, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Full frame missing s_last still processed.
    send_frame(N, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Watchdog abort.
    no_done = 1'b1;
    base = tmo_seen;
    send_frame(N, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (tmo_seen == base && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (tmo_seen == base) note_fail("timeout_wait");
    @(posedge clk); #1;
    no_done = 1'b0;

    // Done on the last allowed WAIT cycle, plus a spurious done during START.
    rmode = 0; lat = TMO; early_done = 1'b1;
    send_frame(N, 1'b1, 1'b0, 1'b1);
    wait_idle();
    early_done = 1'b0;

    // Reset in the middle of unload.
    lat = 4;
    base = beats_seen;
    send_frame(N, 1'b1, 1'b1, 1'b1);
    guard = 0;
    while (beats_seen < base + 3 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (beats_seen < base + 3) note_fail("unload_wait");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_m_valid", m_valid, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    send_frame(N, 1'b1, 1'b0, 1'b1);
    wait_idle();
    chk("frame_cnt_after_rst", frame_cnt, 1);

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      rmode = $urandom_range(0, 2);
      lat   = $urandom_range(1, 20);
      if ($urandom_range(0, 4) == 0) send_frame($urandom_range(1, N-1), 1'b1, 1'b0, 1'b0);
      send_frame(N, 1'b1, 1'b0, 1'b1);
    end
    wait_idle();
    repeat (5) @(posedge clk);
    chk("leftover_bins", q1.size(), 0);
    chk("leftover_bins_nat", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fft8_stream_ctrl.md
# fft8_stream_ctrl

Frame sequencer that wraps the 8-point FFT core with valid/ready streams. Accepts one N-sample complex frame from an input stream, writes it into the core's register file through the core load port, pulses the core start, and waits for done with a watchdog. It then reads the N results out through the core output-select port in natural frequency order onto an output stream. It sits between the system stream fabric and the FFT core top and is the only driver of the core's load, start and out_addr inputs.

## Interface
Parameters:
- N, 8, FFT points; power of two; AW = $clog2(N).
- WIDTH, 12, sample width per real/imag component, two's complement.
- OUT_BITREV, 1, 1: core holds results in bit-reversed slots, so out_addr = bitrev(k). 0: out_addr = k.
- TIMEOUT, 64, max cycles spent in WAIT before abort; ≥ 2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  controller can accept a sample.
- s_re, s_im  in  WIDTH each  input sample.
- s_last  in  1  marks the final sample of a frame.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts the output sample.
- m_re, m_im  out  WIDTH each  output bin.
- m_last  out  1  marks bin N-1.
- core_load  out  1  core register-file write strobe.
- core_load_addr  out  AW  core write address.
- core_data_re, core_data_im  out  WIDTH each  core write data.
- core_start  out  1  core start pulse.
- core_done  in  1  core completion.
- core_out_addr  out  AW  core output select.
- core_out_re, core_out_im  in  WIDTH each  core output data, combinational from core_out_addr.
- err_len  out  1  one-cycle pulse on a frame-length error.
- err_timeout  out  1  one-cycle pulse on a watchdog abort.
- frame_cnt  out  16  completed frames, wraps at 2^16.

## Operation
- States: LOAD, START, WAIT, UNLOAD. Reset state is LOAD. Counters in_cnt (AW), out_cnt (AW), wd_cnt (sized for TIMEOUT).
- LOAD:
  - s_ready = 1.
  - On accept (s_valid && s_ready): core_load = 1, core_load_addr = in_cnt, core_data = s_re/s_im, all combinational from the handshake.
  - Accept with in_cnt == N-1: go to START, in_cnt = 0. If s_last = 0 on that sample, pulse err_len; the frame is still processed.
  - Accept with s_last = 1 and in_cnt < N-1: pulse err_len, drop the frame, in_cnt = 0, stay in LOAD. Already-written slots are overwritten by the next frame.
- START: core_start = 1 for exactly one cycle; wd_cnt = 0; go to WAIT.
- WAIT:
  - core_done = 1: go to UNLOAD, out_cnt = 0.
  - Otherwise wd_cnt increments. At wd_cnt == TIMEOUT-1 with core_done still 0: pulse err_timeout and go to LOAD; the frame is discarded.
- UNLOAD:
  - m_valid = 1.
  - core_out_addr = OUT_BITREV ? bitrev(out_cnt) : out_cnt.
  - m_re/m_im = core_out_re/core_out_im, passed through unregistered.
  - m_last = (out_cnt == N-1).
  - On m_valid && m_ready, out_cnt increments. On the last beat: frame_cnt++ and go to LOAD.
  - m_valid is held with stable data while m_ready = 0.
- Outside UNLOAD, core_out_addr = 0. Outside LOAD, core_load = 0.
- No arithmetic on sample data; widths pass through unchanged.

## Timing
- Reset values while rst = 1, all forced in the same cycle: s_ready, m_valid, m_last, core_load, core_start, err_len, err_timeout = 0. frame_cnt = 0, all counters = 0, state = LOAD.
- s_ready goes high in the first cycle after rst deasserts.
- Last input accepted at cycle t: core_start is high in t+1, WAIT is entered at t+2.
- core_done sampled high at cycle d: m_valid is high from d+1.
- With continuous handshakes, one frame takes N + 2 + core latency + N cycles. There is no overlap between frames.
- Reset mid-frame from any state returns to LOAD, discards all partial data, and produces no error pulses.
- core_done high in the cycle that START is active is ignored. Only done sampled in WAIT counts.
- s_valid is ignored outside LOAD. m_ready is ignored outside UNLOAD.

## Structure
- Shared package fft_pkg holds:
  - the state enum (LOAD/START/WAIT/UNLOAD);
  - the function bitrev(value, AW);
  - the default N and WIDTH constants, also used by the core top.
- Single module, no sub-module. The watchdog is one counter and stays inline.

## Test plan
- Nominal frame: send samples x[i] = (i, 0) for i = 0..7, s_last on i = 7, m_ready held 1, bench model core. Required: core_load_addr 0..7 in order, one core_start pulse, out_addr sequence 0,4,2,6,1,5,3,7, m_last on beat 8 only, frame_cnt = 1.
- Backpressure: toggle m_ready 1,0,0,1 repeatedly. Required: m_re/m_im and core_out_addr are stable while stalled, exactly 8 beats, no duplicated or skipped bin.
- Short frame: s_last on the 5th sample. Required: err_len pulses once, no core_start, next 8-sample frame processes normally.
- Watchdog: core_done held 0 with TIMEOUT = 64. Required: err_timeout pulses exactly 64 cycles after WAIT entry, state returns to LOAD, s_ready = 1 the next cycle.
- Mid-unload reset: assert rst at output beat 3. Required: m_valid = 0 in the same cycle, frame_cnt = 0, next frame starts at core_load_addr 0.
- OUT_BITREV = 0: repeat the nominal frame. Required: out_addr sequence is 0..7.
